// File: rtl/kw4281_display_arbiter.sv
// kw4281_display_arbiter: round-robin owner of the shared 7-segment display with a minimum dwell per grant
//   clk_i    system clock
//   rst_n_i  asynchronous reset, active low
//   req_i    level request per requester
//   val_i    signed 8-bit value per requester, requester k at [8k+7:8k]
//   gnt_o    one-hot grant, zero when nobody owns the display
//   owner_o  index of the current owner, zero when nobody owns the display
//   bin_o    registered value of the owner for the display driver
//   blank_o  high when nobody owns the display
// Optional: define KW4281_ARB_PREEMPT_EN to let a rising req_i[0] (alarm) preempt any owner.
module kw4281_display_arbiter #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int N_REQ           = 4,
    parameter int HOLD_MS         = 500
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*8-1:0]       val_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic [7:0]               bin_o,
    output logic                     blank_o
);
    localparam int          OW   = $clog2(N_REQ);
    localparam logic [31:0] DIV  = 32'(CLOCK_FREQUENCY / 1000);
    localparam logic [15:0] HOLD = 16'(HOLD_MS);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d, rr_q, rr_d, after;
    logic [15:0]     hold_q, hold_d;
    logic [31:0]     presc_q, presc_d;
    logic [7:0]      bin_q, bin_d;
    logic [N_REQ-1:0] others;
    logic            tick, ready;

    // First set bit of m at or after position p, searching cyclically.
    function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] m, input logic [OW-1:0] p);
        logic [OW-1:0] k;
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = OW'((int'(p) + i) % N_REQ);
            if (m[k]) pick = k;
        end
    endfunction

    assign tick    = presc_q == DIV - 32'd1;
    assign presc_d = tick ? '0 : presc_q + 32'd1;
    assign after   = OW'((int'(owner_q) + 1) % N_REQ);
    // Dwell is complete now, either already open or expiring on this tick.
    assign ready   = state_q == S_OPEN || (state_q == S_HOLD && tick && hold_q + 16'd1 >= HOLD);

`ifdef KW4281_ARB_PREEMPT_EN
    logic req0_q, rise0, alarm_own;
    assign rise0     = req_i[0] & ~req0_q;
    // While the alarm owns and still requests, everyone else is invisible.
    assign alarm_own = state_q != S_IDLE && owner_q == '0 && req_i[0];
    assign others    = alarm_own ? '0 : req_i & ~({{(N_REQ-1){1'b0}}, 1'b1} << owner_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) req0_q <= 1'b0;
        else          req0_q <= req_i[0];
    end
`else
    assign others = req_i & ~({{(N_REQ-1){1'b0}}, 1'b1} << owner_q);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
`ifdef KW4281_ARB_PREEMPT_EN
        if (rise0) begin
            state_d = S_HOLD;
            owner_d = '0;
            hold_d  = '0;
        end else
`endif
        if (state_q == S_IDLE) begin
            if (|req_i) begin
                state_d = S_HOLD;
                owner_d = pick(req_i, rr_q);
                hold_d  = '0;
            end
        end else if (|others && (!req_i[owner_q] || ready)) begin
            // Handover: a drop wins over a simultaneous dwell expiry, the outcome is the same grant.
            state_d = S_HOLD;
            owner_d = pick(others, after);
            rr_d    = after;
            hold_d  = '0;
        end else if (!req_i[owner_q]) begin
            state_d = S_IDLE;
            owner_d = '0;
        end else if (state_q == S_HOLD && tick) begin
            hold_d  = hold_q + 16'd1;
            state_d = hold_q + 16'd1 >= HOLD ? S_OPEN : S_HOLD;
        end
    end

    // Follow the next owner so the value lands on the same edge as the grant.
    assign bin_d = state_d != S_IDLE ? val_i[8*owner_d +: 8] : bin_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            presc_q <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            bin_q   <= bin_d;
        end
    end

    assign gnt_o   = state_q == S_IDLE ? '0 : {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign owner_o = owner_q;
    assign bin_o   = bin_q;
    assign blank_o = state_q == S_IDLE;
endmodule

// File: tb/tb_kw4281_display_arbiter.sv
// tb_kw4281_display_arbiter: directed scoreboard bench for the display arbiter (10 clk per ms, 3 ms dwell, 4 requesters)
module tb_kw4281_display_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  v [4];
    logic [31:0] val;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  bin;
    logic        blank;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [7:0] bin;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    assign val = {v[3], v[2], v[1], v[0]};

    always #5 clk = ~clk;

    kw4281_display_arbiter #(
        .CLOCK_FREQUENCY(10000),
        .N_REQ(4),
        .HOLD_MS(3)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .req_i(req),
        .val_i(val),
        .gnt_o(gnt),
        .owner_o(owner),
        .bin_o(bin),
        .blank_o(blank)
    );

    function automatic logic [1:0] idx(input logic [3:0] g);
        return g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        chk({e.tag, ".owner"}, 32'(owner), 32'(idx(e.gnt)));
        chk({e.tag, ".bin"}, 32'(bin), 32'(e.bin));
        chk({e.tag, ".blank"}, 32'(blank), 32'(e.gnt == 4'd0));
    endtask

    task automatic expect_now(input string tag, input logic [3:0] g, input logic [7:0] b);
        sb.push_back('{tag, g, b});
        check_out();
    endtask

    task automatic expect_next(input string tag, input logic [3:0] g, input logic [7:0] b);
        sb.push_back('{tag, g, b});
        step();
        check_out();
    endtask

    task automatic do_reset(input logic [3:0] p);
        rst_n = 1'b0;
        req   = p;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_change(input string tag, input int lo, input int hi);
        logic [3:0] old;
        int n;
        old = gnt;
        n   = 0;
        while (gnt === old && n < hi) begin
            step();
            n++;
        end
        chk($sformatf("%s.cycles=%0d", tag, n), 32'(gnt !== old && n >= lo), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        req   = 4'b1111;
        v[0]  = 8'h05;
        v[1]  = 8'h80;
        v[2]  = 8'h22;
        v[3]  = 8'h33;
        #1;
        expect_now("rst.async", 4'b0000, 8'h00);
        step();
        step();
        expect_now("rst.held", 4'b0000, 8'h00);
        rst_n = 1'b1;
        expect_next("rst.release", 4'b0001, 8'h05);
        rst_n = 1'b0;
        #1;
        expect_now("rst.midgrant", 4'b0000, 8'h00);

        do_reset(4'b1010);
        expect_next("rr.first", 4'b0010, 8'h80);
        wait_change("rr.dwell1", 20, 30);
        expect_now("rr.second", 4'b1000, 8'h33);
        wait_change("rr.dwell2", 20, 30);
        expect_now("rr.wrap", 4'b0010, 8'h80);

        do_reset(4'b0011);
        expect_next("dwell.own0", 4'b0001, 8'h05);
`ifdef KW4281_ARB_PREEMPT_EN
        repeat (40) step();
        expect_now("dwell.alarmkeeps", 4'b0001, 8'h05);
        req = 4'b0010;
        expect_next("dwell.next", 4'b0010, 8'h80);
`else
        wait_change("dwell.min", 20, 30);
        expect_now("dwell.next", 4'b0010, 8'h80);
`endif
        req = 4'b0100;
        expect_next("single.take", 4'b0100, 8'h22);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (gnt !== 4'b0100) bad++;
        end
        chk("single.stays", 32'(bad), 32'd0);

        do_reset(4'b1010);
        expect_next("drop.own1", 4'b0010, 8'h80);
        repeat (3) step();
        req = 4'b1000;
        expect_next("drop.handover", 4'b1000, 8'h33);
        req = 4'b0000;
        expect_next("drop.idle", 4'b0000, 8'h33);

        do_reset(4'b0001);
        expect_next("live.own0", 4'b0001, 8'h05);
        v[0] = 8'hF9;
        expect_next("live.neg", 4'b0001, 8'hF9);
        v[2] = 8'h7F;
        expect_next("live.other", 4'b0001, 8'hF9);
        v[0] = 8'h05;
        v[2] = 8'h22;

        do_reset(4'b0100);
        expect_next("pre.own2", 4'b0100, 8'h22);
        step();
        step();
        req = 4'b0101;
`ifdef KW4281_ARB_PREEMPT_EN
        expect_next("pre.alarm", 4'b0001, 8'h05);
`else
        expect_next("pre.noalarm", 4'b0100, 8'h22);
        wait_change("pre.dwell", 1, 30);
        expect_now("pre.after", 4'b0001, 8'h05);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
